prgrom_loader: RTL and testbench
================================

Name: prgrom_loader

Overview:
- Fills instruction memory from a UART byte stream before the CPU runs, so a program can be loaded without rebuilding the bitstream.
- Sits directly upstream of the fetch stage. It drives the write port of the instruction memory; the fetch stage reads the same memory using word address pc[15:2].
- Holds the CPU through cpu_hold while loading. Loading starts on a start pulse; a 16-bit word count precedes the instruction words.

Parameters:
ADDR_W, 14, width of the instruction-memory word address; capacity is 2^ADDR_W words
TIMEOUT_CYCLES, 1000000, maximum idle cycles allowed between bytes during a load before it aborts

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse; arms a load
rx_data  input  8  byte from the UART receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid while high
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  word address for the write
wr_data  output  32  assembled instruction word
cpu_hold  output  1  holds the CPU (fetch PC) in reset while high
busy  output  1  high in LEN_LO, LEN_HI and DATA
done  output  1  held high after a successful load
error  output  1  held high after an aborted load
words_loaded  output  ADDR_W+1  count of words written in the current or last load

Behaviour:
- Reset (reset==0 at a rising edge):
  - state goes to IDLE.
  - All outputs go to 0, including cpu_hold. Byte index, length register and timeout counter are cleared.
  - Reset overrides every other input, including mid-load; a partial word is dropped.
- States: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR. busy is decoded from state; all other outputs are registered.
- IDLE/DONE/ERR:
  - rx_valid is ignored.
  - start=1 moves to LEN_LO, sets cpu_hold=1, and clears done, error, words_loaded, byte index and timeout counter.
- LEN_LO: on an accepted byte, len[7:0] = rx_data and move to LEN_HI.
- LEN_HI: on an accepted byte, len[15:8] = rx_data, then:
  - len==0 goes to DONE.
  - len > 2^ADDR_W goes to ERR.
  - Otherwise go to DATA.
- DATA, byte assembly:
  - Bytes are little-endian: byte k (k=0..3) goes into word bits [8k+7:8k].
  - On the edge that accepts byte 3: wr_en=1 (for exactly that next cycle), wr_addr=words_loaded[ADDR_W-1:0], wr_data=assembled word, words_loaded increments, byte index returns to 0.
  - If the new words_loaded == len, the state moves to DONE on the same edge.
- DONE: done=1. cpu_hold falls on the edge after DONE is entered, so the final wr_en completes while the CPU is still held.
- ERR: error=1 and cpu_hold stays 1; the CPU is never released onto a partial image. Only start or reset leaves ERR.
- Timeout:
  - The counter runs only in LEN_LO, LEN_HI and DATA, and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 without a byte, the state moves to ERR. A partial word is discarded and no wr_en is issued.
- Simultaneous events:
  - rx_valid in the same cycle as timeout expiry: the byte wins and the counter clears.
  - start while busy: ignored.
- Write latency: one cycle from the 4th byte strobe to wr_en. wr_addr never wraps because len is bounded by capacity.

Decomposition:
- Package prgrom_loader_pkg: state encoding localparams, byte-order constant, and the counter-width function clog2(TIMEOUT_CYCLES).
- One sub-module, loader_timeout: a clearable, enableable counter with an expire flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Hold reset=0 for 5 cycles while toggling rx_valid and start -> every output stays 0; state stays IDLE.
- start; bytes 02 00 78 56 34 12 EF BE AD DE -> wr_en pulse at addr 0 with 0x12345678, then at addr 1 with 0xDEADBEEF; then done=1, words_loaded=2, cpu_hold=0 one cycle later, error=0.
- start; bytes 00 00 -> DONE with no wr_en; done=1.
- ADDR_W=4; start; bytes 11 00 (len 17 > 16) -> error=1, cpu_hold=1, no wr_en.
- TIMEOUT_CYCLES=16; start; bytes 01 00 AA BB, then silence -> error=1 exactly 15 cycles after the BB strobe, no wr_en. A following start with bytes 01 00 01 02 03 04 -> addr 0 written with 0x04030201, done=1.
- Reset driven low after 2 data bytes of a 1-word load -> all outputs 0, no write. A new start with bytes 01 00 11 22 33 44 -> addr 0 written with 0x44332211.

Source files
------------

// File: rtl/prgrom_loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : prgrom_loader_pkg
// Brief    : State encoding, byte-order constant and width helper for the loader
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package prgrom_loader_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    // Byte 0 of each instruction word lands in bits [7:0].
    localparam bit LITTLE_ENDIAN = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) width = i + 1;
        end
        return width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prgrom_loader_timeout.sv
//------------------------------------------------------------------------------
// Module   : loader_timeout
// Brief    : Clearable idle counter; expire fires on the edge it reaches TIMEOUT_CYCLES-1
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module loader_timeout
    import prgrom_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int c_CNT_W = clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 2);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || !enable) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // Asserted in the cycle whose closing edge would bring the count to TIMEOUT_CYCLES-1.
    assign expire = enable && !clear && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/prgrom_loader.sv
//------------------------------------------------------------------------------
// Module   : prgrom_loader
// Brief    : Loads instruction memory from a UART byte stream while holding the CPU
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prgrom_loader
    import prgrom_loader_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] c_CAPACITY = 17'(1) << ADDR_W;

    logic [2:0]        r_state;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_word;
    logic [ADDR_W:0]   r_words;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;

    logic              w_busy;
    logic              w_accept;
    logic              w_expire;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic [15:0]       w_len_full;
    logic [ADDR_W:0]   w_words_inc;

    assign w_busy      = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) || (r_state == ST_DATA);
    assign w_accept    = w_busy && rx_valid;
    assign w_lane      = LITTLE_ENDIAN ? r_byte_idx : ~r_byte_idx;
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_words_inc = r_words + (ADDR_W + 1)'(1);

    always_comb begin
        w_word = r_word;
        w_word[8*w_lane +: 8] = rx_data;
    end

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .enable(w_busy),
        .clear (w_accept),
        .expire(w_expire)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_words    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    // The CPU is released one edge after DONE, never from ERR.
                    if (r_state == ST_DONE) r_cpu_hold <= 1'b0;
                    if (start) begin
                        r_state    <= ST_LEN_LO;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_words    <= '0;
                        r_byte_idx <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= ST_LEN_HI;
                    end else if (w_expire) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if (w_len_full == 16'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if ({1'b0, w_len_full} > c_CAPACITY) begin
                            r_state <= ST_ERR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else if (w_expire) begin
                        r_state <= ST_ERR;
                        r_error <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_word     <= w_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_words[ADDR_W-1:0];
                            r_wr_data <= w_word;
                            r_words   <= w_words_inc;
                            if (17'(w_words_inc) == {1'b0, r_len}) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end else if (w_expire) begin
                        r_state    <= ST_ERR;
                        r_error    <= 1'b1;
                        r_byte_idx <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy         = w_busy;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

`default_nettype wire

// File: tb/tb_prgrom_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_prgrom_loader
// Brief    : Directed self-checking bench for prgrom_loader (ADDR_W=4, TIMEOUT_CYCLES=16)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prgrom_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [4:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    int          wr_count = 0;
    logic [3:0]  log_addr [0:15];
    logic [31:0] log_data [0:15];

    prgrom_loader #(
        .ADDR_W        (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            if (wr_count < 16) begin
                log_addr[wr_count] = wr_addr;
                log_data[wr_count] = wr_data;
            end
            wr_count = wr_count + 1;
        end
    end

    // Caller sits at a negedge; each byte is accepted on the following posedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [45:0] obs;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start    = i[0];
            rx_valid = ~i[0];
            rx_data  = 8'(8'h5A + i);
            @(negedge clock);
            obs = {wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, words_loaded};
            total++;
            if (obs !== 46'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
            end
        end
        start    = 1'b0;
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_two_words();
        int w0;
        w0 = wr_count;
        pulse_start();
        total++;
        if ({cpu_hold, busy} !== 2'b11) begin
            bad++;
            $display("FAIL two_words_armed: got hold/busy %b expected 11", {cpu_hold, busy});
        end
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        total++;
        if ({wr_en, done, cpu_hold, busy, words_loaded} !== {4'b1110, 5'd2}) begin
            bad++;
            $display("FAIL two_words_last_edge: got en/done/hold/busy/words %b_%0d expected 1110_2",
                     {wr_en, done, cpu_hold, busy}, words_loaded);
        end
        @(negedge clock);
        total++;
        if ({wr_en, done, error, cpu_hold} !== 4'b0100) begin
            bad++;
            $display("FAIL two_words_release: got en/done/err/hold %b expected 0100",
                     {wr_en, done, error, cpu_hold});
        end
        total++;
        if (wr_count - w0 !== 2) begin
            bad++;
            $display("FAIL two_words_count: got %0d writes expected 2", wr_count - w0);
        end
        total++;
        if ({log_addr[w0], log_data[w0]} !== {4'd0, 32'h12345678}) begin
            bad++;
            $display("FAIL two_words_w0: got addr %0d data %h expected addr 0 data 12345678",
                     log_addr[w0], log_data[w0]);
        end
        total++;
        if ({log_addr[w0+1], log_data[w0+1]} !== {4'd1, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL two_words_w1: got addr %0d data %h expected addr 1 data deadbeef",
                     log_addr[w0+1], log_data[w0+1]);
        end
    endtask

    task automatic test_zero_len();
        int w0;
        w0 = wr_count;
        pulse_start();
        total++;
        if ({done, words_loaded} !== 6'd0) begin
            bad++;
            $display("FAIL zero_len_cleared: got done %b words %0d expected 0 0", done, words_loaded);
        end
        send_byte(8'h00); send_byte(8'h00);
        total++;
        if ({done, busy, cpu_hold} !== 3'b101) begin
            bad++;
            $display("FAIL zero_len_done: got done/busy/hold %b expected 101", {done, busy, cpu_hold});
        end
        @(negedge clock);
        total++;
        if ({cpu_hold, wr_count - w0} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL zero_len_release: got hold %b writes %0d expected 0 0", cpu_hold, wr_count - w0);
        end
    endtask

    task automatic test_overflow();
        int w0;
        w0 = wr_count;
        pulse_start();
        send_byte(8'h11); send_byte(8'h00);
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({error, cpu_hold, done, busy} !== 4'b1100) begin
            bad++;
            $display("FAIL overflow_err: got err/hold/done/busy %b expected 1100", {error, cpu_hold, done, busy});
        end
        total++;
        if (wr_count - w0 !== 0) begin
            bad++;
            $display("FAIL overflow_writes: got %0d expected 0", wr_count - w0);
        end
    endtask

    task automatic test_timeout();
        int w0;
        w0 = wr_count;
        pulse_start();
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_cleared: got %b expected 0", error);
        end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (i == 14) begin
                total++;
                if (error !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_early: got error %b at cycle 14 expected 0", error);
                end
            end
        end
        total++;
        if ({error, cpu_hold, busy} !== 3'b110) begin
            bad++;
            $display("FAIL timeout_expire: got err/hold/busy %b at cycle 15 expected 110", {error, cpu_hold, busy});
        end
        total++;
        if (wr_count - w0 !== 0) begin
            bad++;
            $display("FAIL timeout_writes: got %0d expected 0", wr_count - w0);
        end
        w0 = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        @(negedge clock);
        total++;
        if ({wr_count - w0, log_addr[w0], log_data[w0]} !== {32'd1, 4'd0, 32'h04030201}) begin
            bad++;
            $display("FAIL timeout_reload: got writes %0d addr %0d data %h expected 1 0 04030201",
                     wr_count - w0, log_addr[w0], log_data[w0]);
        end
        total++;
        if ({done, error, words_loaded} !== {2'b10, 5'd1}) begin
            bad++;
            $display("FAIL timeout_reload_done: got done/err %b words %0d expected 10 1", {done, error}, words_loaded);
        end
    endtask

    task automatic test_reset_midload();
        int w0;
        logic [45:0] obs;
        w0 = wr_count;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        reset = 1'b0;
        @(negedge clock);
        obs = {wr_en, wr_addr, wr_data, cpu_hold, busy, done, error, words_loaded};
        total++;
        if (obs !== 46'd0) begin
            bad++;
            $display("FAIL midload_reset: got %h expected 0", obs);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (wr_count - w0 !== 0) begin
            bad++;
            $display("FAIL midload_writes: got %0d expected 0", wr_count - w0);
        end
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clock);
        total++;
        if ({wr_count - w0, log_addr[w0], log_data[w0]} !== {32'd1, 4'd0, 32'h44332211}) begin
            bad++;
            $display("FAIL midload_reload: got writes %0d addr %0d data %h expected 1 0 44332211",
                     wr_count - w0, log_addr[w0], log_data[w0]);
        end
        total++;
        if ({done, cpu_hold} !== 2'b10) begin
            bad++;
            $display("FAIL midload_done: got done/hold %b expected 10", {done, cpu_hold});
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clock);
        test_reset();
        test_two_words();
        test_zero_len();
        test_overflow();
        test_timeout();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
